// File: rtl/demux_deser16.sv
// Receiving end of a 16:1 mux serializer: each accepted serial bit is demultiplexed
// into one slot of a shadow word, and the completed word is published on dout.
module demux_deser16 #(
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        start,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        busy,
    output logic [3:0]  sel,
    output logic        err,
    output logic [7:0]  frame_cnt
);

    // din_valid qualifies din and start for the current cycle; when it is low the
    // block holds every register, so the sender may insert gaps of any length.
    // There is no backpressure: every qualified bit is accepted on the rising edge.

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] shadow;
    logic [3:0]  bit_idx;
    logic [3:0]  slot;
    logic [15:0] word_next;

    // A start always restarts at index 0; otherwise the incoming bit is index sel.
    always_comb begin
        bit_idx = 4'd0;
        if (state == RECV && !start) begin
            bit_idx = sel;
        end
        slot = (MSB_FIRST != 0) ? ~bit_idx : bit_idx;
        word_next = shadow;
        word_next[slot] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= 16'h0000;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
            sel        <= 4'h0;
            err        <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            dout_valid <= 1'b0;
            err        <= 1'b0;
            if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            shadow <= word_next;
                            sel    <= 4'd1;
                            state  <= RECV;
                        end
                    end
                    RECV: begin
                        if (start) begin
                            // Abort: the partial frame is dropped, dout stays untouched.
                            shadow <= word_next;
                            sel    <= 4'd1;
                            err    <= 1'b1;
                        end else if (sel == 4'd15) begin
                            shadow     <= word_next;
                            dout       <= word_next;
                            dout_valid <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            sel        <= 4'd0;
                            state      <= IDLE;
                        end else begin
                            shadow <= word_next;
                            sel    <= sel + 4'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_demux_deser16.sv
// Bench for demux_deser16: one LSB-first and one MSB-first instance share a serial
// stream; a bit-list reference model predicts every completed word and abort.
module tb_demux_deser16;

    localparam int W = 56;  // {cycle[31:0], frame_cnt[7:0], dout[15:0]}

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        start;

    logic [15:0] dout0, dout1;
    logic        dv0, dv1;
    logic        busy0, busy1;
    logic [3:0]  sel0, sel1;
    logic        err0, err1;
    logic [7:0]  fc0, fc1;

    demux_deser16 #(.MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
        .dout(dout0), .dout_valid(dv0), .busy(busy0), .sel(sel0), .err(err0),
        .frame_cnt(fc0)
    );

    demux_deser16 #(.MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .start(start),
        .dout(dout1), .dout_valid(dv1), .busy(busy1), .sel(sel1), .err(err1),
        .frame_cnt(fc1)
    );

    // ---------------- clock / reset ----------------
    int unsigned cyc;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int n_checks;
    int n_pass;

    // Reference model: the bits of the frame in progress, plus the last published words.
    logic        bits[$];
    logic [15:0] last0, last1;
    logic [7:0]  cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        bits.delete();
        last0 = 16'h0000;
        last1 = 16'h0000;
        cnt   = 8'h00;
    endtask

    // Checks the registered outputs of both instances against the model.
    task automatic check_state(input logic exp_err);
        check("busy0", 64'(busy0), 64'(bits.size() > 0));
        check("busy1", 64'(busy1), 64'(bits.size() > 0));
        check("sel0", 64'(sel0), 64'(bits.size()));
        check("sel1", 64'(sel1), 64'(bits.size()));
        check("err0", 64'(err0), 64'(exp_err));
        check("err1", 64'(err1), 64'(exp_err));
        check("dout0", 64'(dout0), 64'(last0));
        check("dout1", 64'(dout1), 64'(last1));
        check("frame_cnt0", 64'(fc0), 64'(cnt));
        check("frame_cnt1", 64'(fc1), 64'(cnt));
    endtask

    // ---------------- driver ----------------
    task automatic drv(input logic v, input logic s, input logic d);
        logic        exp_err;
        logic [15:0] w0, w1;
        exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (bits.size() > 0) exp_err = 1'b1;
                bits.delete();
                bits.push_back(d);
            end else if (bits.size() > 0) begin
                bits.push_back(d);
                if (bits.size() == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        w0[k]      = bits[k];
                        w1[15 - k] = bits[k];
                    end
                    cnt   = cnt + 8'd1;
                    last0 = w0;
                    last1 = w1;
                    exp_q0.push_back({32'(cyc + 1), cnt, w0});
                    exp_q1.push_back({32'(cyc + 1), cnt, w1});
                    bits.delete();
                end
            end
        end
        din_valid = v;
        start     = s;
        din       = d;
        @(posedge clk);
        #1;
        check_state(exp_err);
    endtask

    // Sends bits [first, first+n) of a word; bit index 0 carries start.
    task automatic send_bits(input logic [15:0] word, input bit msb, input int first,
                             input int n, input int max_gap);
        for (int k = first; k < first + n; k++) begin
            if (max_gap > 0 && k != first) begin
                int g;
                g = $urandom_range(1, max_gap);
                for (int j = 0; j < g; j++) drv(1'b0, 1'($urandom_range(0, 1)), 1'($urandom));
            end
            drv(1'b1, (k == 0), msb ? word[15 - k] : word[k]);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drv(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_check();
        check("rst dout0", 64'(dout0), 64'h0);
        check("rst dout1", 64'(dout1), 64'h0);
        check("rst dv0", 64'(dv0), 64'h0);
        check("rst busy0", 64'(busy0), 64'h0);
        check("rst sel0", 64'(sel0), 64'h0);
        check("rst err0", 64'(err0), 64'h0);
        check("rst frame_cnt0", 64'(fc0), 64'h0);
        check("rst busy1", 64'(busy1), 64'h0);
    endtask

    // Asserts reset mid-cycle (asynchronous), releases it just after a rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        din_valid = 1'b0;
        start = 1'b0;
        model_reset();
        #1;
        reset_check();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (dv0) begin
            if (exp_q0.size() == 0) check("dv0 unexpected", 64'(dout0), 64'hx);
            else check("dout0 on valid", {8'h0, 32'(cyc), fc0, dout0}, 64'(exp_q0.pop_front()));
        end
        if (dv1) begin
            if (exp_q1.size() == 0) check("dv1 unexpected", 64'(dout1), 64'hx);
            else check("dout1 on valid", {8'h0, 32'(cyc), fc1, dout1}, 64'(exp_q1.pop_front()));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        din = 1'b0;
        din_valid = 1'b0;
        start = 1'b0;
        model_reset();
        #3;
        reset_check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Continuous LSB-first frame.
        send_bits(16'h05FA, 1'b0, 0, 16, 0);
        idle(2);
        check("basic dout", 64'(dout0), 64'h05FA);
        check("basic frame_cnt", 64'(fc0), 64'h01);

        // Same word with gaps (start pulses during gaps have din_valid=0).
        do_reset();
        send_bits(16'h05FA, 1'b0, 0, 16, 5);
        idle(2);
        check("gap dout", 64'(dout0), 64'h05FA);

        // Aborted partial frame followed by a full frame.
        do_reset();
        send_bits(16'hFFFF, 1'b0, 0, 7, 0);
        send_bits(16'hA5A5, 1'b0, 0, 16, 0);
        idle(2);
        check("abort dout", 64'(dout0), 64'hA5A5);
        check("abort frame_cnt", 64'(fc0), 64'h01);

        // Reset mid-frame, headless bits ignored, then a fresh frame.
        do_reset();
        send_bits(16'hBEEF, 1'b0, 0, 10, 0);
        do_reset();
        send_bits(16'h7777, 1'b0, 1, 5, 0);
        send_bits(16'h1234, 1'b0, 0, 16, 0);
        idle(2);
        check("post-reset dout", 64'(dout0), 64'h1234);

        // MSB-first ordering on the second instance.
        do_reset();
        send_bits(16'h05FA, 1'b1, 0, 16, 0);
        idle(2);
        check("msb dout1", 64'(dout1), 64'h05FA);

        // 256 back-to-back frames, frame n = n.
        do_reset();
        for (int n = 0; n < 256; n++) send_bits(16'(n), 1'b0, 0, 16, 0);
        idle(2);
        check("wrap frame_cnt", 64'(fc0), 64'h00);
        check("wrap dout", 64'(dout0), 64'h00FF);

        // Random frames with random aborts and gaps.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) send_bits(16'($urandom), 1'b0, 0, $urandom_range(1, 15), 2);
            send_bits(16'($urandom), 1'($urandom_range(0, 1)), 0, 16, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);

        check("exp_q0 drained", 64'(exp_q0.size()), 64'h0);
        check("exp_q1 drained", 64'(exp_q1.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_deser16.md
DEMUX_DESER16 -- requirements
Module: demux_deser16

Interface
REQ-001 Parameter: MSB_FIRST, default 0, bit-order select; 0 = first bit lands in slot 0, 1 = first bit lands in slot 15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
REQ-004 Port: din  input  1  serial data bit; sampled only when din_valid=1.
REQ-005 Port: din_valid  input  1  qualifies din for the current cycle.
REQ-006 Port: start  input  1  marks din as bit 0 of a new frame; effective only with din_valid=1.
REQ-007 Port: dout  output  16  last completely assembled word; registered.
REQ-008 Port: dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-009 Port: busy  output  1  high while a frame is partially received (state RECV).
REQ-010 Port: sel  output  4  index of the next bit to be received; registered.
REQ-011 Port: err  output  1  one-cycle pulse when a frame is aborted by a new start.
REQ-012 Port: frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-013 The block SHALL be the receiving end of a 16:1 mux serializer: the bit received at index k SHALL be routed (demultiplexed) into slot k of an internal 16-bit shadow register (slot 15-k when MSB_FIRST=1).
REQ-014 States SHALL be IDLE and RECV only; busy = (state==RECV).
REQ-015 IDLE: din_valid=1 and start=1 -> write din to slot for index 0, sel<=1, go RECV; any other input combination -> no state change, din ignored.
REQ-016 RECV, din_valid=1, start=0: write din to slot for index sel, sel<=sel+1.
REQ-017 RECV, din_valid=0: hold all state; gaps of any length SHALL be tolerated.
REQ-018 RECV, din_valid=1, start=1: abort current frame, pulse err for one cycle, treat din as bit 0 of a new frame (sel<=1, remain RECV); dout, dout_valid and frame_cnt SHALL NOT change.
REQ-019 RECV, sel==15, din_valid=1, start=0: on that edge dout<= completed word (shadow plus this bit), dout_valid<=1 for exactly one cycle, frame_cnt<=frame_cnt+1, sel<=0, go IDLE.
REQ-020 Latency: dout/dout_valid SHALL be visible in the cycle immediately after the edge sampling bit 15.
REQ-021 Back-to-back: a start with din_valid in the cycle dout_valid is high SHALL be accepted with no bubble.
REQ-022 dout SHALL hold its value between completions; a partial or aborted frame SHALL never alter dout.
REQ-023 sel SHALL wrap 15->0 only via completion (REQ-019); no other wrap path exists.
REQ-024 start with din_valid=0 SHALL be ignored in every state.

Reset
REQ-025 On rst_n=0: state=IDLE, shadow=16'h0000, dout=16'h0000, dout_valid=0, busy=0, sel=4'h0, err=0, frame_cnt=8'h00, regardless of clk.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first accepted bit after release SHALL require start=1.

Verification
REQ-027 MSB_FIRST=0, send 16'h05FA LSB-first, start on bit 0, din_valid continuous -> dout=16'h05FA, dout_valid one cycle after 16th bit, frame_cnt=1, err never asserted.
REQ-028 Same word with random din_valid gaps (1-5 cycles) between bits -> identical dout=16'h05FA; sel holds during gaps; busy high from bit 0 to completion.
REQ-029 Send 7 bits of 16'hFFFF, then start with frame 16'hA5A5 -> err pulses once, dout stays 16'h0000 until dout=16'hA5A5, frame_cnt=1.
REQ-030 Assert rst_n=0 after bit 9 of a frame -> all outputs reset values immediately; bits sent without start afterwards ignored; next start frame 16'h1234 -> dout=16'h1234.
REQ-031 MSB_FIRST=1, send 16'h05FA MSB-first -> dout=16'h05FA.
REQ-032 256 back-to-back frames with no bubble (frame n = n) -> each dout_valid pulse carries expected value, frame_cnt wraps to 8'h00 after the 256th frame.
